// File: rtl/sample_voice_addr_gen.sv
// sample_voice_addr_gen: time-multiplexed per-voice fractional sample address generator
module sample_voice_addr_gen #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int BRAM_DEPTH = 8192,
  parameter int FRAC_WIDTH = 8,
  parameter int STEP_WIDTH = 12
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             sample_tick,
  input  logic [NUM_VOICES-1:0]            gate_in,
  input  logic [2*NUM_VOICES-1:0]          mode_in,
  input  logic [STEP_WIDTH*NUM_VOICES-1:0] step_in,
  input  logic [ADDR_WIDTH-1:0]            loop_start_in,
  input  logic [ADDR_WIDTH-1:0]            loop_end_in,
  output logic [ADDR_WIDTH*NUM_VOICES-1:0] sample_addr,
  output logic                             addr_valid,
  output logic [NUM_VOICES-1:0]            voice_active,
  output logic [NUM_VOICES-1:0]            done_pulse,
  output logic                             overrun_pulse
);
  localparam int PW = ADDR_WIDTH + FRAC_WIDTH;
  localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam logic [PW:0] DEPTH_FX = (PW+1)'(BRAM_DEPTH) << FRAC_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(BRAM_DEPTH - 1);
  localparam logic [PW-1:0] LAST_FX = PW'(BRAM_DEPTH - 1) << FRAC_WIDTH;
  typedef enum logic [1:0] {IDLE, SWEEP, PUBLISH} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [PW-1:0] phase [NUM_VOICES];
  logic [NUM_VOICES-1:0] finished, pending;
  logic [1:0] mode;
  logic [STEP_WIDTH-1:0] step;
  logic [PW:0] sum, wrap_reg, len_fx;
  logic [PW-1:0] wrap_full, phase_nxt;
  logic [ADDR_WIDTH:0] end_addr, len;
  logic region, over, reg_hi, one_shot;
  // sequencer: one voice slot per cycle, then a single publish cycle
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    if (state == IDLE && sample_tick) begin
      state_nxt = SWEEP;
      idx_nxt = '0;
    end else if (state == SWEEP) begin
      idx_nxt = idx == IW'(NUM_VOICES - 1) ? '0 : idx + IW'(1);
      state_nxt = idx == IW'(NUM_VOICES - 1) ? PUBLISH : SWEEP;
    end else if (state == PUBLISH) begin
      state_nxt = IDLE;
    end
  end
  // next phase of the voice in the current slot, with end-of-sample handling
  always_comb begin
    mode = mode_in[idx*2 +: 2];
    step = step_in[idx*STEP_WIDTH +: STEP_WIDTH];
    sum = {1'b0, phase[idx]} + (PW+1)'(step);
    region = mode == 2'b10 && loop_start_in <= loop_end_in;
    one_shot = mode == 2'b00;
    end_addr = region ? {1'b0, loop_end_in} : LAST;
    over = sum[PW:FRAC_WIDTH] > end_addr;
    len = {1'b0, loop_end_in} - {1'b0, loop_start_in} + (ADDR_WIDTH+1)'(1);
    len_fx = (PW+1)'(len) << FRAC_WIDTH;
    wrap_full = PW'(sum - DEPTH_FX);
    wrap_reg = sum - len_fx;
    reg_hi = wrap_reg[PW:FRAC_WIDTH] > {1'b0, loop_end_in};
    phase_nxt = !over ? sum[PW-1:0] : one_shot ? LAST_FX : !region ? wrap_full :
                reg_hi ? {loop_start_in, {FRAC_WIDTH{1'b0}}} : wrap_reg[PW-1:0];
  end
  // state, publication strobes and per-voice phase bookkeeping
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      idx <= '0;
      sample_addr <= '0;
      addr_valid <= 1'b0;
      done_pulse <= '0;
      overrun_pulse <= 1'b0;
      voice_active <= '0;
      finished <= '0;
      pending <= '0;
      for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      overrun_pulse <= sample_tick && state != IDLE;
      addr_valid <= state == PUBLISH;
      done_pulse <= state == PUBLISH ? pending : '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (state == PUBLISH) begin
          sample_addr[v*ADDR_WIDTH +: ADDR_WIDTH] <= phase[v][PW-1:FRAC_WIDTH];
          pending[v] <= 1'b0;
        end
        if (!gate_in[v]) begin
          phase[v] <= '0;
          voice_active[v] <= 1'b0;
          finished[v] <= 1'b0;
          pending[v] <= 1'b0;
        end else if (state == SWEEP && idx == IW'(v)) begin
          if (!voice_active[v] && !finished[v]) begin
            voice_active[v] <= 1'b1;
            phase[v] <= '0;
          end else if (voice_active[v]) begin
            phase[v] <= phase_nxt;
            if (over && one_shot) begin
              voice_active[v] <= 1'b0;
              finished[v] <= 1'b1;
              pending[v] <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: doc/sample_voice_addr_gen.md
SAMPLE_VOICE_ADDR_GEN -- requirements
Module: sample_voice_addr_gen

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of independent playback voices, minimum 1.
REQ-002 Parameter ADDR_WIDTH, default 13: width of the sample address integer part.
REQ-003 Parameter BRAM_DEPTH, default 8192: samples per voice memory, at most 2^ADDR_WIDTH.
REQ-004 Parameter FRAC_WIDTH, default 8: fractional bits of the phase and step.
REQ-005 Parameter STEP_WIDTH, default 12: total step width, unsigned fixed point with FRAC_WIDTH fraction bits.
REQ-006 clk_in  input  1  single system clock; all state changes on its rising edge.
REQ-007 rst_in  input  1  reset, synchronous and active-high.
REQ-008 sample_tick  input  1  one-cycle strobe requesting one address advance for all voices.
REQ-009 gate_in  input  NUM_VOICES  per-voice note gate; bit v belongs to voice v.
REQ-010 mode_in  input  2*NUM_VOICES  per-voice mode: 00 one-shot, 01 loop full, 10 loop region, 11 treated as 01.
REQ-011 step_in  input  STEP_WIDTH*NUM_VOICES  per-voice unsigned phase increment per tick.
REQ-012 loop_start_in, loop_end_in  input  ADDR_WIDTH each  shared inclusive loop region bounds.
REQ-013 sample_addr  output  ADDR_WIDTH*NUM_VOICES  published integer address per voice, voice v at bits [v*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 addr_valid  output  1  one-cycle strobe marking a new sample_addr publication.
REQ-015 voice_active  output  NUM_VOICES  voice currently advancing.
REQ-016 done_pulse  output  NUM_VOICES  one-cycle strobe, coincident with addr_valid, when a one-shot voice reaches the end.
REQ-017 overrun_pulse  output  1  one-cycle strobe when sample_tick arrives while a sweep is in progress.

Function
REQ-018 The FSM SHALL have states IDLE, SWEEP and PUBLISH; sample_tick in IDLE moves it to SWEEP with voice index 0.
REQ-019 In SWEEP, the FSM SHALL process exactly one voice per cycle, index 0 to NUM_VOICES-1, then enter PUBLISH for one cycle, then return to IDLE.
REQ-020 At the end of PUBLISH, sample_addr SHALL load every voice's phase integer part and addr_valid SHALL pulse; sample_tick high in cycle T gives addr_valid high in cycle T+NUM_VOICES+2.
REQ-021 sample_tick outside IDLE SHALL be ignored and SHALL raise overrun_pulse the following cycle.
REQ-022 Each voice phase SHALL be ADDR_WIDTH+FRAC_WIDTH bits; additions SHALL use one extra carry bit so no overflow is lost.
REQ-023 gate_in[v] low in any cycle SHALL clear voice v phase to 0, voice_active[v] to 0 and its finished flag to 0 on the next edge; the published address follows at the next PUBLISH.
REQ-024 At its slot with gate high, a voice neither active nor finished SHALL become active with phase 0 and no advance that sweep.
REQ-025 At its slot, an active voice SHALL set phase to phase+step; step 0 holds the address.
REQ-026 End address SHALL be loop_end_in in mode 10, else BRAM_DEPTH-1.
REQ-027 If a mode 00 sum integer part exceeds end: phase integer BRAM_DEPTH-1, fraction 0, voice_active 0, finished 1, done_pulse at that publication; it stays until gate falls and rises.
REQ-028 If a mode 01 sum integer part exceeds end, the SHALL-be-stored value is sum minus BRAM_DEPTH, fraction preserved.
REQ-029 If a mode 10 sum integer part exceeds loop_end_in, the stored value SHALL be sum minus region length (loop_end_in-loop_start_in+1), fraction preserved; if still above loop_end_in, integer loop_start_in and fraction 0.
REQ-030 Mode 10 with loop_start_in > loop_end_in SHALL behave as mode 01.
REQ-031 mode_in, step_in and loop bounds SHALL be sampled at each voice's slot only.

Reset
REQ-032 rst_in high SHALL force, on the next edge: FSM IDLE, index 0, all phases 0, all finished flags 0, sample_addr 0, voice_active 0, addr_valid, done_pulse and overrun_pulse 0, overriding every other input, including mid-sweep.

Verification
REQ-033 Reset mid-sweep -> next cycle all outputs 0, FSM IDLE, no addr_valid pulse.
REQ-034 Voice 0 gate rise, mode 01, step 0x100, ticks every 20 cycles -> addr_valid at tick cycle+6 (NUM_VOICES 4); addr sequence 0,1,2,3.
REQ-035 Step 0x080 -> published addresses 0,0,1,1,2; step 0 -> address held.
REQ-036 Mode 00, step 0x100, phase at 8191 -> next publication 8191, done_pulse[0]=1, voice_active[0]=0; further ticks hold 8191 until gate falls then rises.
REQ-037 Mode 10, loop 100..103, step 0x200, address 102 -> next 100; mode 01 with step 0x280 at 8190.0 -> 0.5, address 0.
REQ-038 Tick during sweep -> overrun_pulse once, single addr_valid; gate_in[2] low mid-sweep -> voice 2 address 0 at next publication.
